mac_accum_requant: RTL and testbench
====================================

// Module: mac_accum_requant
// PURPOSE
//  Consumer end of the signed dual-multiply-add stream: accepts 33-bit signed partial sums and
//  accumulates cfg_len of them into one kernel-window total. Round-shifts and saturates the total
//  back to a 16-bit signed activation. Presents it on a valid/ready output to the next CNN layer.
// PARAMETERS
//  IN_W   33  width of signed input partial sum
//  ACC_W  48  accumulator width; must be >= IN_W+LEN_W (no internal overflow possible)
//  OUT_W  16  width of signed requantized output
//  LEN_W  8   width of cfg_len (max 2^LEN_W-1 terms per group)
// PORTS
//  clock     in   1      rising-edge clock
//  aclr      in   1      asynchronous active-high reset
//  clear     in   1      synchronous abort: drop partial group and pending output
//  cfg_len   in   LEN_W  terms per group; latched on first beat of a group; 0 treated as 1
//  cfg_shift in   6      right-shift amount; latched with cfg_len; valid range 0..ACC_W-1
//  in_valid  in   1      in_data valid
//  in_data   in   IN_W   signed partial sum
//  in_ready  out  1      beat accepted when in_valid & in_ready at rising edge
//  out_valid out  1      out_data/out_sat valid
//  out_data  out  OUT_W  signed requantized result
//  out_sat   out  1      result was clamped
//  out_ready in   1      downstream accepts when out_valid & out_ready
//  busy      out  1      group in progress (state != IDLE)
// BEHAVIOUR
//  Reset (aclr=1): state=IDLE; acc, cnt, out_data=0; out_valid=0; out_sat=0; busy=0.
//   In IDLE, in_ready=1 even while aclr is held.
//  FSM:
//   IDLE:  in_ready=1. On accepted beat: acc=sext(in_data); cnt=1; latch len/shift.
//          Go to ROUND if len<=1, else ACCUM.
//   ACCUM: in_ready=1. On accepted beat: acc+=sext(in_data); cnt++.
//          Go to ROUND when cnt+1==len. Idle cycles (in_valid=0) hold state.
//   ROUND: in_ready=0; one cycle. s=shift; r=(s==0)?acc:(acc+2^(s-1))>>>s (round half up,
//          arithmetic shift). Clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Register out_data;
//          out_sat=1 iff clamped. Set out_valid=1; go to HOLD.
//   HOLD:  in_ready=0. out_valid, out_data, out_sat held stable until out_ready=1.
//          On that edge: out_valid=0; go to IDLE. out_data retains its last value.
//  Latency: last beat accepted at edge T; out_valid=1 after edge T+1. Upstream must honour
//   in_ready; 2 idle input cycles minimum between groups (ROUND + HOLD >= 1 cycle each).
//  clear: highest priority after aclr. On edge with clear=1: state=IDLE; acc=0; cnt=0;
//   out_valid=0; out_sat=0; any simultaneous input beat is discarded.
//  aclr mid-operation: immediate return to reset values; partial group is lost.
//  cfg_len/cfg_shift changes mid-group have no effect until the next group.
// CONFIGURATION
//  MAC_ACC_RELU_EN defined: in ROUND, r<0 forces r=0 before clamp (out_sat=0 for negatives).
//  Undefined: signed result passes through; negatives are clamped only at -2^(OUT_W-1).
// TESTING
//  1 len=4,shift=0; beats 10,20,-5,7 back-to-back -> out_data=32, out_sat=0, out_valid at T+1
//  2 len=1,shift=4; beat 24 -> 2; next group beat -24 -> -1; beat 8 -> 1 (half rounds up)
//  3 len=2,shift=0; beats 40000,1 -> 32767, out_sat=1; beat pair -40000,-1 -> -32768, out_sat=1
//  4 HOLD with out_ready=0 for 5 cycles -> out_valid/out_data stable, in_ready=0,
//    offered beats not consumed; out_ready=1 -> IDLE next cycle, in_ready=1
//  5 len=4; clear after 2 beats, then new group len=2 of 3,4 -> 7 (no residue);
//    aclr pulse in HOLD -> out_valid=0 immediately, busy=0
//  6 len=1,shift=0; beat -100 -> 0 with MAC_ACC_RELU_EN, -100 without; out_sat=0 both

Source files
------------

// File: rtl/mac_accum_requant.sv
// mac_accum_requant: accumulates a group of cfg_len signed partial sums from the
// dual-multiply-add stream, then round-shifts and saturates the total to a signed
// OUT_W activation. The result is presented on a valid/ready port to the next layer.
// Optional build macro: MAC_ACC_RELU_EN. When it is defined, negative results are
// forced to zero before the clamp.
module mac_accum_requant #(
    parameter int IN_W  = 33,
    parameter int ACC_W = 48,
    parameter int OUT_W = 16,
    parameter int LEN_W = 8
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             clear,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [5:0]       cfg_shift,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ROUND, S_HOLD} state_t;

    // Clamp limits, held one bit wider than the accumulator so rounding cannot wrap.
    localparam logic signed [ACC_W:0] C_MAX =
        $signed({{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [ACC_W:0] C_MIN =
        $signed({{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}});
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    state_t             r_state;
    state_t             w_next_state;
    logic [ACC_W-1:0]   r_acc;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_len;
    logic [5:0]         r_shift;
    logic               r_out_valid;
    logic [OUT_W-1:0]   r_out_data;
    logic               r_out_sat;

    logic               w_in_ready;
    logic               w_accept;
    logic [LEN_W-1:0]   w_len_eff;
    logic [ACC_W-1:0]   w_in_ext;
    logic signed [ACC_W:0] w_half;
    logic signed [ACC_W:0] w_sum;
    logic signed [ACC_W:0] w_rnd;
    logic signed [ACC_W:0] w_rect;
    logic [OUT_W-1:0]   w_out;
    logic               w_sat;

    // Input side is open only while collecting a group; clear discards any beat.
    assign w_in_ready = (r_state == S_IDLE) || (r_state == S_ACCUM);
    assign w_accept   = in_valid && w_in_ready && !clear;
    assign w_len_eff  = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    assign w_in_ext   = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};

    assign in_ready  = w_in_ready;
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

    // State register.
    always_ff @(posedge clock or posedge aclr) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (aclr) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    // Next-state decode: group collection, one rounding cycle, then handshake hold.
    always_comb begin
        // NOTE: default first so every path assigns w_next_state and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = (w_len_eff <= LEN_W'(1)) ? S_ROUND : S_ACCUM;
            S_ACCUM: if (w_accept && ((r_cnt + LEN_W'(1)) == r_len)) w_next_state = S_ROUND;
            S_ROUND: w_next_state = S_HOLD;
            S_HOLD:  if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (clear) w_next_state = S_IDLE;
    end

    // Round half up, arithmetic shift, optional rectification, then saturate.
    always_comb begin
        w_half = '0;
        if (r_shift != 6'd0) w_half = $signed({{ACC_W{1'b0}}, 1'b1} << (r_shift - 6'd1));
        w_sum = $signed({r_acc[ACC_W-1], r_acc}) + w_half;
        w_rnd = w_sum >>> r_shift;
`ifdef MAC_ACC_RELU_EN
        w_rect = w_rnd[ACC_W] ? '0 : w_rnd;
`else
        w_rect = w_rnd;
`endif
        w_sat = 1'b0;
        w_out = w_rect[OUT_W-1:0];
        if (w_rect > C_MAX) begin
            w_out = OUT_MAX;
            w_sat = 1'b1;
        end else if (w_rect < C_MIN) begin
            w_out = OUT_MIN;
            w_sat = 1'b1;
        end
    end

    // Accumulator, beat counter, latched group config and output register.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_shift     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else if (clear) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_acc   <= w_in_ext;
                    r_cnt   <= LEN_W'(1);
                    r_len   <= w_len_eff;
                    r_shift <= cfg_shift;
                end
                S_ACCUM: if (w_accept) begin
                    r_acc <= r_acc + w_in_ext;
                    r_cnt <= r_cnt + LEN_W'(1);
                end
                S_ROUND: begin
                    r_out_data  <= w_out;
                    r_out_sat   <= w_sat;
                    r_out_valid <= 1'b1;
                end
                S_HOLD: if (out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accum_requant.sv
// Self-checking bench for mac_accum_requant: directed cases plus randomized groups
// compared against an arithmetic model of the group sum, rounding and clamp.
module tb_mac_accum_requant;

    localparam int IN_W  = 33;
    localparam int ACC_W = 48;
    localparam int OUT_W = 16;
    localparam int LEN_W = 8;

    logic             clock = 1'b0;
    logic             aclr;
    logic             clear;
    logic [LEN_W-1:0] cfg_len;
    logic [5:0]       cfg_shift;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    logic             out_ready;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    longint beats[$];

    mac_accum_requant #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
        .clock(clock), .aclr(aclr), .clear(clear), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_sat(out_sat), .out_ready(out_ready), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: sum, round half up at 2^-s, optional ReLU, clamp to OUT_W signed.
    function automatic void model(input longint sum, input int s, output longint r, output bit sat);
        longint lo, hi;
        lo = -(64'sd1 <<< (OUT_W-1));
        hi = (64'sd1 <<< (OUT_W-1)) - 1;
        r = (s == 0) ? sum : ((sum + (64'sd1 <<< (s-1))) >>> s);
`ifdef MAC_ACC_RELU_EN
        if (r < 0) r = 0;
`endif
        sat = 1'b0;
        if (r > hi) begin r = hi; sat = 1'b1; end
        if (r < lo) begin r = lo; sat = 1'b1; end
    endfunction

    function automatic longint rand_beat(input bit wide);
        logic [IN_W-1:0] v;
        if (!wide) return longint'($urandom_range(0, 4000)) - 2000;
        v[31:0] = $urandom();
        v[32]   = 1'($urandom_range(0, 1));
        return longint'($signed(v));
    endfunction

    // Drives one full group from beats[], checks latency, result, hold and release.
    task automatic run_group(input int len_cfg, input int shift, input int hold_cycles, input int gap_max);
        longint sum = 0;
        longint exp_r;
        bit     exp_s;
        for (int i = 0; i < beats.size(); i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) tick();
            if (i == 0) begin
                cfg_len   = LEN_W'(len_cfg);
                cfg_shift = 6'(shift);
            end
            in_valid = 1'b1;
            in_data  = beats[i][IN_W-1:0];
            sum += beats[i];
            check("in_ready_beat", in_ready, 1);
            tick();
            cfg_len   = LEN_W'($urandom());
            cfg_shift = 6'($urandom());
        end
        in_valid = 1'b0;
        model(sum, shift, exp_r, exp_s);
        check("round_out_valid", out_valid, 0);
        check("round_busy", busy, 1);
        check("round_in_ready", in_ready, 0);
        tick();
        check("lat_out_valid", out_valid, 1);
        check("out_data", longint'($signed(out_data)), exp_r);
        check("out_sat", out_sat, longint'(exp_s));
        for (int h = 0; h < hold_cycles; h++) begin
            in_valid = 1'b1;
            in_data  = IN_W'(rand_beat(1'b0));
            tick();
            check("hold_out_valid", out_valid, 1);
            check("hold_out_data", longint'($signed(out_data)), exp_r);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("rel_out_valid", out_valid, 0);
        check("rel_in_ready", in_ready, 1);
        check("rel_busy", busy, 0);
        check("rel_retain", longint'($signed(out_data)), exp_r);
    endtask

    initial begin
        aclr = 1'b1; clear = 1'b0; cfg_len = '0; cfg_shift = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        aclr = 1'b0;
        tick();

        // Back-to-back group of four.
        beats = '{10, 20, -5, 7};
        run_group(4, 0, 0, 0);
        check("t1_sum", longint'($signed(out_data)), 32);

        // Single-beat groups with rounding, including half values.
        beats = '{24};  run_group(1, 4, 0, 0);
        check("t2_pos", longint'($signed(out_data)), 2);
        beats = '{-24}; run_group(1, 4, 0, 0);
        check("t2_neg", longint'($signed(out_data)), -1);
        beats = '{8};   run_group(1, 4, 0, 0);
        check("t2_half", longint'($signed(out_data)), 1);

        // Saturation at both rails, with a 5-cycle hold on the first.
        beats = '{40000, 1};   run_group(2, 0, 5, 0);
        check("t3_hi", longint'($signed(out_data)), 32767);
        beats = '{-40000, -1}; run_group(2, 0, 0, 0);
`ifndef MAC_ACC_RELU_EN
        check("t3_lo", longint'($signed(out_data)), -32768);
`endif

        // Zero length is a one-term group.
        beats = '{-3}; run_group(0, 0, 0, 1);

        // Abort after two beats; the beat offered with clear is discarded.
        cfg_len = 8'd4; cfg_shift = 6'd0;
        in_valid = 1'b1; in_data = IN_W'(100); tick();
        in_data = IN_W'(200); tick();
        check("clr_busy_before", busy, 1);
        clear = 1'b1; in_data = IN_W'(999); tick();
        clear = 1'b0; in_valid = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_out_valid", out_valid, 0);
        check("clr_in_ready", in_ready, 1);
        beats = '{3, 4}; run_group(2, 0, 0, 0);
        check("t5_no_residue", longint'($signed(out_data)), 7);

        // Asynchronous reset while holding a result.
        cfg_len = 8'd1; cfg_shift = 6'd0;
        in_valid = 1'b1; in_data = IN_W'(5); tick();
        in_valid = 1'b0; tick();
        check("aclr_pre_valid", out_valid, 1);
        #2 aclr = 1'b1;
        #1;
        check("aclr_out_valid", out_valid, 0);
        check("aclr_busy", busy, 0);
        check("aclr_out_data", out_data, 0);
        check("aclr_in_ready", in_ready, 1);
        tick();
        aclr = 1'b0;
        tick();

        // Negative single term: passes through, or rectified to zero with ReLU.
        beats = '{-100}; run_group(1, 0, 0, 0);
`ifdef MAC_ACC_RELU_EN
        check("t6_relu", longint'($signed(out_data)), 0);
`else
        check("t6_norelu", longint'($signed(out_data)), -100);
`endif
        check("t6_sat", out_sat, 0);

        // Randomized groups: mixed lengths, shifts, gaps and hold times.
        for (int g = 0; g < 40; g++) begin
            int  sel, len, n, sh;
            bit  wide;
            sel  = $urandom_range(0, 9);
            len  = (sel == 0) ? 0 : (sel == 1) ? 255 : $urandom_range(1, 8);
            n    = (len == 0) ? 1 : len;
            wide = 1'($urandom_range(0, 1));
            sh   = wide ? $urandom_range(0, ACC_W-1) : $urandom_range(0, 12);
            beats.delete();
            for (int b = 0; b < n; b++) beats.push_back(rand_beat(wide));
            run_group(len, sh, $urandom_range(0, 3), 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
